// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO-fed, 5..DBIT_MAX data bits,
// none/even/odd parity, 1/1.5/2 stop bits, back-to-back frames.
module uart_tx_cfg #(
  parameter int DBIT_MAX   = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_tick,
  input  logic [1:0]                      cfg_dbits,
  input  logic [1:0]                      cfg_parity,
  input  logic [1:0]                      cfg_stop,
  input  logic [DBIT_MAX-1:0]             din,
  input  logic                            din_valid,
  output logic                            din_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            tx_done_tick,
  output logic                            tx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(DBIT_MAX);
  localparam int SW = $clog2(2 * OVS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DBIT_MAX-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  state_t              r_state;
  logic [SW-1:0]       r_s;
  logic [NW-1:0]       r_n;
  logic [NW-1:0]       r_last_bit;
  logic [DBIT_MAX-1:0] r_shift;
  logic                r_par_en;
  logic                r_par_bit;
  logic [SW-1:0]       r_stop_last;
  logic                r_tx;
  logic                r_done;

  logic                w_push;
  logic                w_pop;
  logic                w_bit_end;
  logic                w_stop_end;
  logic [DBIT_MAX-1:0] w_head;
  logic [DBIT_MAX-1:0] w_mask;
  int                  w_nbits;
  logic [SW-1:0]       w_stop_last;
  logic                w_par_en;
  logic                w_par_bit;

  assign din_ready    = (r_count != CW'(FIFO_DEPTH));
  assign fifo_count   = r_count;
  assign busy         = (r_state != ST_IDLE);
  assign tx_done_tick = r_done;
  assign tx           = r_tx;

  assign w_push     = din_valid && din_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_end  = s_tick && (r_s == SW'(OVS - 1));
  assign w_stop_end = (r_state == ST_STOP) && s_tick && (r_s == r_stop_last);
  // A new frame starts from IDLE or straight out of the last stop tick.
  assign w_pop      = (r_count != '0) && ((r_state == ST_IDLE) || w_stop_end);

  // Frame parameters derived from the live config, latched only at pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_nbits = 5 + int'(cfg_dbits);
    if (w_nbits > DBIT_MAX) w_nbits = DBIT_MAX;
    w_mask = '0;
    for (int i = 0; i < DBIT_MAX; i++) w_mask[i] = (i < w_nbits);
    case (cfg_stop)
      2'b00:   w_stop_last = SW'(OVS - 1);
      2'b01:   w_stop_last = SW'((3 * OVS) / 2 - 1);
      default: w_stop_last = SW'(2 * OVS - 1);
    endcase
    w_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    w_par_bit = (^(w_head & w_mask)) ^ (cfg_parity == 2'b10);
  end

  // NOTE: FIFO storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_last_bit  <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_last <= '0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: r_tx <= 1'b1;
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_s     <= '0;
            r_n     <= '0;
            r_tx    <= r_shift[0];
          end else if (s_tick) begin
            r_s <= r_s + SW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_s     <= '0;
            r_shift <= r_shift >> 1;
            if (r_n == r_last_bit) begin
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_n  <= r_n + NW'(1);
              r_tx <= r_shift[1];
            end
          end else if (s_tick) begin
            r_s <= r_s + SW'(1);
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_s     <= '0;
            r_tx    <= 1'b1;
          end else if (s_tick) begin
            r_s <= r_s + SW'(1);
          end
        end
        ST_STOP: begin
          if (w_stop_end) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_s     <= '0;
          end else if (s_tick) begin
            r_s <= r_s + SW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Starting a frame overrides whatever the case above chose.
      if (w_pop) begin
        r_state     <= ST_START;
        r_s         <= '0;
        r_shift     <= w_head;
        r_last_bit  <= NW'(w_nbits - 1);
        r_par_en    <= w_par_en;
        r_par_bit   <= w_par_bit;
        r_stop_last <= w_stop_last;
        r_tx        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor decodes each frame
// (mid-bit samples, s_tick length, gap) and the stimulus checks it.
module tb_uart_tx_cfg;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] cfg_dbits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic [1:0] cfg_stop = 2'b00;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       tx_done_tick;
  logic       tx;

  int total = 0;
  int bad = 0;

  uart_tx_cfg #(.DBIT_MAX(8), .OVS(OVS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .fifo_count(fifo_count), .busy(busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  always #5 clk = ~clk;

  // s_tick: one clk wide, every 4th clk, changed on the falling edge.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      s_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Line monitor, sampled 1 time unit after each rising edge.
  int          frames = 0;
  int          done_cnt = 0;
  logic [15:0] f_cap [16];
  int          f_n [16];
  int          f_ticks [16];
  int          f_b2b [16];
  int          f_busy [16];
  logic [15:0] m_cap;
  int          m_n, m_ticks, m_busy, m_b2b;
  bit          m_in = 1'b0;
  bit          m_end;

  always @(posedge clk) begin
    #1;
    m_end = 1'b0;
    if (reset) begin
      m_in = 1'b0;
    end else begin
      if (tx_done_tick) done_cnt++;
      if (m_in) begin
        if (s_tick) begin
          m_ticks++;
          if (!tx_done_tick && (m_ticks % OVS == OVS / 2) && m_n < 16) begin
            m_cap[m_n] = tx;
            m_n++;
          end
        end
        if (tx_done_tick) begin
          if (frames < 16) begin
            f_cap[frames]   = m_cap;
            f_n[frames]     = m_n;
            f_ticks[frames] = m_ticks;
            f_b2b[frames]   = m_b2b;
            f_busy[frames]  = m_busy;
          end
          frames++;
          m_in  = 1'b0;
          m_end = 1'b1;
        end else if (!busy) begin
          m_busy = 0;
        end
      end
      if (!m_in && tx == 1'b0) begin
        m_in    = 1'b1;
        m_ticks = 0;
        m_n     = 0;
        m_cap   = '0;
        m_busy  = 1;
        m_b2b   = m_end ? 1 : 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (frames < n && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_frames"}, frames, n);
  endtask

  task automatic check_frame(input string tag, input int idx, input int cap,
                             input int n, input int ticks, input int b2b);
    check({tag, "_bits"}, 32'(f_cap[idx]), cap);
    check({tag, "_nsamp"}, f_n[idx], n);
    check({tag, "_ticks"}, f_ticks[idx], ticks);
    check({tag, "_b2b"}, f_b2b[idx], b2b);
    check({tag, "_busy"}, f_busy[idx], 1);
  endtask

  initial begin : stim
    logic [7:0] burst [5];
    int dc0;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_ready", din_ready, 1);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;

    // 8N1, 0x55
    cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop = 2'b00;
    push_byte(8'h55);
    wait_frames("f8n1", 1);
    check_frame("f8n1", 0, 32'h2AA, 10, 160, 0);
    check("f8n1_done", done_cnt, 1);
    @(negedge clk);
    check("f8n1_idle", busy, 0);

    // 7E2, 0x41
    cfg_dbits = 2'b10; cfg_parity = 2'b01; cfg_stop = 2'b10;
    push_byte(8'h41);
    wait_frames("f7e2", 2);
    check_frame("f7e2", 1, 32'h682, 11, 176, 0);

    // 5O1.5, 0xFF
    cfg_dbits = 2'b00; cfg_parity = 2'b10; cfg_stop = 2'b01;
    push_byte(8'hFF);
    wait_frames("f5o15", 3);
    check_frame("f5o15", 2, 32'hBE, 8, 136, 0);
    check("f5o15_done", done_cnt, 3);

    // Burst of five bytes with din_valid held high
    cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = burst[i];
      din_valid = 1'b1;
    end
    @(negedge clk);
    din = 8'h66;
    check("burst_full_cnt", fifo_count, 4);
    check("burst_full_rdy", din_ready, 0);
    repeat (3) @(negedge clk);
    check("burst_refused", fifo_count, 4);
    din_valid = 1'b0;
    wait_frames("burst", 8);
    for (int i = 0; i < 5; i++)
      check_frame("burst", 3 + i, (int'(burst[i]) << 1) | 32'h200, 10, 160, (i == 0) ? 0 : 1);
    check("burst_done", done_cnt, 8);
    @(negedge clk);
    check("burst_empty", fifo_count, 0);

    // Config change while the current frame is in DATA
    push_byte(8'hA5);
    repeat (100) @(negedge clk);
    check("cfgchg_busy", busy, 1);
    cfg_dbits = 2'b10; cfg_parity = 2'b01; cfg_stop = 2'b10;
    push_byte(8'h3C);
    wait_frames("cfgchg", 10);
    check_frame("cfgchg_a", 8, 32'h34A, 10, 160, 0);
    check_frame("cfgchg_b", 9, 32'h678, 11, 176, 1);

    // Reset during DATA bit 3 with two entries queued
    cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop = 2'b00;
    push_byte(8'h80);
    push_byte(8'h81);
    push_byte(8'h82);
    repeat (300) @(negedge clk);
    check("pre_rst_count", fifo_count, 2);
    check("pre_rst_tx", tx, 0);
    dc0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", din_ready, 1);
    check("mid_rst_done", tx_done_tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_nodone", done_cnt, dc0);
    check("mid_rst_frames", frames, 10);

    // New frame after reset
    push_byte(8'h0F);
    wait_frames("post_rst", 11);
    check_frame("post_rst", 10, 32'h21E, 10, 160, 0);
    check("post_rst_done", done_cnt, dc0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
